// File: rtl/btb_assoc.sv
// btb_assoc
//
// N-way set-associative branch target buffer. Each entry has a valid bit,
// a tag, a 32-bit target, a branch/jump flag and a 2-bit saturating direction
// counter. Each set has a round-robin victim pointer.
//
// The IF stage looks up IF_pc combinationally. The ID stage writes back one
// resolved branch or jump per cycle. A write that hits updates the entry in
// place. A write that misses allocates the lowest invalid way, or the
// round-robin victim when the set is full. flush invalidates everything on
// the next edge and wins over a simultaneous write.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst_n         asynchronous active-low reset; clears the whole array
//   IF_pc         fetch PC to look up
//   pc_imm_out    predicted target of the hitting way (0 on miss)
//   hit           IF_pc matches a valid entry
//   IF_Branch     hitting entry is a conditional branch
//   IF_Jump       hitting entry is a jump
//   predict_taken hit && (IF_Jump || ctr[1])
//   write         ID update request
//   ID_pc         PC of the resolved instruction
//   pc_imm_in     resolved target
//   ID_Branch     1 = branch, 0 = jump
//   ID_taken      resolved direction (ignored for jumps)
//   flush         synchronous invalidate of all entries and pointers
module btb_assoc #(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2,
  parameter int SET_BITS  = $clog2(NUM_SETS),
  parameter int TAG_WIDTH = 30 - SET_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_pc,
  output logic [31:0] pc_imm_out,
  output logic        hit,
  output logic        IF_Branch,
  output logic        IF_Jump,
  output logic        predict_taken,
  input  logic        write,
  input  logic [31:0] ID_pc,
  input  logic [31:0] pc_imm_in,
  input  logic        ID_Branch,
  input  logic        ID_taken,
  input  logic        flush
);

  // A way index needs at least one bit. With a single way, the storage gets
  // one spare slot so that the way index width always matches the array
  // depth. The spare slot is never searched or written, so it stays invalid.
  localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WAY_SLOTS = 1 << WAY_BITS;

  // Saturating increment of a 2-bit direction counter.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b11;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Saturating decrement of a 2-bit direction counter.
  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b00;
      2'b10:   r = 2'b01;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  logic                 valid_r     [NUM_SETS][WAY_SLOTS];
  logic [TAG_WIDTH-1:0] tag_r       [NUM_SETS][WAY_SLOTS];
  logic [31:0]          target_r    [NUM_SETS][WAY_SLOTS];
  logic                 is_branch_r [NUM_SETS][WAY_SLOTS];
  logic [1:0]           ctr_r       [NUM_SETS][WAY_SLOTS];
  logic [WAY_BITS-1:0]  rr_ptr_r    [NUM_SETS];

  logic [SET_BITS-1:0]  rd_idx_s;
  logic [TAG_WIDTH-1:0] rd_tag_s;
  logic                 rd_hit_s;
  logic [WAY_BITS-1:0]  rd_way_s;

  logic [SET_BITS-1:0]  wr_idx_s;
  logic [TAG_WIDTH-1:0] wr_tag_s;
  logic                 wr_hit_s;
  logic [WAY_BITS-1:0]  wr_hit_way_s;
  logic                 inv_found_s;
  logic [WAY_BITS-1:0]  inv_way_s;
  logic [WAY_BITS-1:0]  wr_way_s;
  logic [1:0]           ctr_old_s;
  logic [1:0]           ctr_new_s;
  logic [WAY_BITS-1:0]  rr_next_s;
  logic                 alloc_rr_s;

  // The byte-offset bits of a PC do not take part in indexing or tagging.
  logic                 unused_pc_bits_s;
  assign unused_pc_bits_s = ^{IF_pc[1:0], ID_pc[1:0]};

  assign rd_idx_s = IF_pc[2+SET_BITS-1:2];
  assign rd_tag_s = IF_pc[31:2+SET_BITS];
  assign wr_idx_s = ID_pc[2+SET_BITS-1:2];
  assign wr_tag_s = ID_pc[31:2+SET_BITS];

  // Fetch-side tag match. The scan runs from the top way down, so the lowest
  // matching way is the one selected.
  always_comb begin
    rd_hit_s = 1'b0;
    rd_way_s = {WAY_BITS{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      rd_hit_s = rd_hit_s | (valid_r[rd_idx_s][w] && (tag_r[rd_idx_s][w] == rd_tag_s));
      rd_way_s = (valid_r[rd_idx_s][w] && (tag_r[rd_idx_s][w] == rd_tag_s))
                 ? WAY_BITS'(w) : rd_way_s;
    end
  end

  assign hit = rd_hit_s;

  // Prediction outputs. All of them are forced to zero on a miss.
  always_comb begin
    if (rd_hit_s) begin
      pc_imm_out    = target_r[rd_idx_s][rd_way_s];
      IF_Branch     = is_branch_r[rd_idx_s][rd_way_s];
      IF_Jump       = ~is_branch_r[rd_idx_s][rd_way_s];
      predict_taken = ~is_branch_r[rd_idx_s][rd_way_s] | ctr_r[rd_idx_s][rd_way_s][1];
    end else begin
      pc_imm_out    = 32'h0000_0000;
      IF_Branch     = 1'b0;
      IF_Jump       = 1'b0;
      predict_taken = 1'b0;
    end
  end

  // Search of the update-side set for a matching way and the lowest invalid way.
  always_comb begin
    wr_hit_s     = 1'b0;
    wr_hit_way_s = {WAY_BITS{1'b0}};
    inv_found_s  = 1'b0;
    inv_way_s    = {WAY_BITS{1'b0}};
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      wr_hit_s     = wr_hit_s | (valid_r[wr_idx_s][w] && (tag_r[wr_idx_s][w] == wr_tag_s));
      wr_hit_way_s = (valid_r[wr_idx_s][w] && (tag_r[wr_idx_s][w] == wr_tag_s))
                     ? WAY_BITS'(w) : wr_hit_way_s;
      inv_found_s  = inv_found_s | ~valid_r[wr_idx_s][w];
      inv_way_s    = (~valid_r[wr_idx_s][w]) ? WAY_BITS'(w) : inv_way_s;
    end
  end

  // Way selection: in-place hit first, then a free way, then the victim pointer.
  always_comb begin
    if (wr_hit_s) begin
      wr_way_s = wr_hit_way_s;
    end else if (inv_found_s) begin
      wr_way_s = inv_way_s;
    end else begin
      wr_way_s = rr_ptr_r[wr_idx_s];
    end
  end

  assign alloc_rr_s = ~wr_hit_s & ~inv_found_s;

  // Pointer advance. Natural truncation of the width provides the wrap; with
  // a single way there is no pointer, so it stays at zero.
  always_comb begin
    if (NUM_WAYS > 1) begin
      rr_next_s = rr_ptr_r[wr_idx_s] + WAY_BITS'(1'b1);
    end else begin
      rr_next_s = {WAY_BITS{1'b0}};
    end
  end

  // New counter value. A jump pins the counter to strongly taken. A branch
  // hit trains the counter. A branch allocation starts weak in the resolved
  // direction.
  always_comb begin
    ctr_old_s = ctr_r[wr_idx_s][wr_hit_way_s];
    if (!ID_Branch) begin
      ctr_new_s = 2'b11;
    end else if (wr_hit_s) begin
      if (ID_taken) begin
        ctr_new_s = ctr_inc(ctr_old_s);
      end else begin
        ctr_new_s = ctr_dec(ctr_old_s);
      end
    end else if (ID_taken) begin
      ctr_new_s = 2'b10;
    end else begin
      ctr_new_s = 2'b01;
    end
  end

  // Array state: async clear, flush invalidate, or single-entry update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_ptr_r[s] <= {WAY_BITS{1'b0}};
        for (int w = 0; w < WAY_SLOTS; w++) begin
          valid_r[s][w]     <= 1'b0;
          tag_r[s][w]       <= {TAG_WIDTH{1'b0}};
          target_r[s][w]    <= 32'h0000_0000;
          is_branch_r[s][w] <= 1'b0;
          ctr_r[s][w]       <= 2'b00;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_ptr_r[s] <= {WAY_BITS{1'b0}};
        for (int w = 0; w < WAY_SLOTS; w++) begin
          valid_r[s][w] <= 1'b0;
        end
      end
    end else if (write) begin
      valid_r[wr_idx_s][wr_way_s]     <= 1'b1;
      tag_r[wr_idx_s][wr_way_s]       <= wr_tag_s;
      target_r[wr_idx_s][wr_way_s]    <= pc_imm_in;
      is_branch_r[wr_idx_s][wr_way_s] <= ID_Branch;
      ctr_r[wr_idx_s][wr_way_s]       <= ctr_new_s;
      if (alloc_rr_s) begin
        rr_ptr_r[wr_idx_s] <= rr_next_s;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc. Four configurations run side by side on
// the same stimulus: (16 sets, 2 ways), (64, 4), (2, 1) and (2, 8). Each DUT
// is compared against an abstract per-configuration model of sets of entries,
// indexed with PC word-address arithmetic.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IF_pc, ID_pc, pc_imm_in;
  logic        write, ID_Branch, ID_taken, flush;

  logic [31:0] tgt_o [4];
  logic        hit_o [4];
  logic        br_o  [4];
  logic        jmp_o [4];
  logic        pt_o  [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_assoc #(.NUM_SETS(16), .NUM_WAYS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .pc_imm_out(tgt_o[0]), .hit(hit_o[0]),
    .IF_Branch(br_o[0]), .IF_Jump(jmp_o[0]), .predict_taken(pt_o[0]), .write(write),
    .ID_pc(ID_pc), .pc_imm_in(pc_imm_in), .ID_Branch(ID_Branch), .ID_taken(ID_taken),
    .flush(flush));
  btb_assoc #(.NUM_SETS(64), .NUM_WAYS(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .pc_imm_out(tgt_o[1]), .hit(hit_o[1]),
    .IF_Branch(br_o[1]), .IF_Jump(jmp_o[1]), .predict_taken(pt_o[1]), .write(write),
    .ID_pc(ID_pc), .pc_imm_in(pc_imm_in), .ID_Branch(ID_Branch), .ID_taken(ID_taken),
    .flush(flush));
  btb_assoc #(.NUM_SETS(2), .NUM_WAYS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .pc_imm_out(tgt_o[2]), .hit(hit_o[2]),
    .IF_Branch(br_o[2]), .IF_Jump(jmp_o[2]), .predict_taken(pt_o[2]), .write(write),
    .ID_pc(ID_pc), .pc_imm_in(pc_imm_in), .ID_Branch(ID_Branch), .ID_taken(ID_taken),
    .flush(flush));
  btb_assoc #(.NUM_SETS(2), .NUM_WAYS(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .IF_pc(IF_pc), .pc_imm_out(tgt_o[3]), .hit(hit_o[3]),
    .IF_Branch(br_o[3]), .IF_Jump(jmp_o[3]), .predict_taken(pt_o[3]), .write(write),
    .ID_pc(ID_pc), .pc_imm_in(pc_imm_in), .ID_Branch(ID_Branch), .ID_taken(ID_taken),
    .flush(flush));

  // Reference model: per configuration, per set, a list of entries plus a victim pointer.
  bit          m_valid [4][64][8];
  int unsigned m_tag   [4][64][8];
  int unsigned m_tgt   [4][64][8];
  bit          m_br    [4][64][8];
  int          m_ctr   [4][64][8];
  int          m_rr    [4][64];

  function automatic int sets_of(input int c);
    return (c == 0) ? 16 : (c == 1) ? 64 : 2;
  endfunction

  function automatic int ways_of(input int c);
    return (c == 0) ? 2 : (c == 1) ? 4 : (c == 2) ? 1 : 8;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 64; s++) begin
        m_rr[c][s] = 0;
        for (int w = 0; w < 8; w++) begin
          m_valid[c][s][w] = 0; m_tag[c][s][w] = 0; m_tgt[c][s][w] = 0;
          m_br[c][s][w] = 0; m_ctr[c][s][w] = 0;
        end
      end
  endtask

  task automatic model_flush();
    for (int c = 0; c < 4; c++)
      for (int s = 0; s < 64; s++) begin
        m_rr[c][s] = 0;
        for (int w = 0; w < 8; w++) m_valid[c][s][w] = 0;
      end
  endtask

  task automatic model_write();
    for (int c = 0; c < 4; c++) begin
      int S = sets_of(c);
      int W = ways_of(c);
      int unsigned idx = (ID_pc >> 2) % S;
      int unsigned tg  = (ID_pc >> 2) / S;
      int way = -1;
      for (int w = 0; w < W; w++)
        if (way < 0 && m_valid[c][idx][w] && m_tag[c][idx][w] == tg) way = w;
      if (way >= 0) begin
        if (!ID_Branch) m_ctr[c][idx][way] = 3;
        else if (ID_taken) m_ctr[c][idx][way] = (m_ctr[c][idx][way] == 3) ? 3 : m_ctr[c][idx][way] + 1;
        else m_ctr[c][idx][way] = (m_ctr[c][idx][way] == 0) ? 0 : m_ctr[c][idx][way] - 1;
      end else begin
        for (int w = 0; w < W; w++)
          if (way < 0 && !m_valid[c][idx][w]) way = w;
        if (way < 0) begin
          way = m_rr[c][idx];
          m_rr[c][idx] = (m_rr[c][idx] + 1) % W;
        end
        m_valid[c][idx][way] = 1;
        m_tag[c][idx][way]   = tg;
        m_ctr[c][idx][way]   = !ID_Branch ? 3 : (ID_taken ? 2 : 1);
      end
      m_tgt[c][idx][way] = pc_imm_in;
      m_br[c][idx][way]  = ID_Branch;
    end
  endtask

  task automatic model_lookup(input int c, input logic [31:0] pc, output bit h,
                              output logic [31:0] t, output bit b, output bit j, output bit p);
    int S = sets_of(c);
    int W = ways_of(c);
    int unsigned idx = (pc >> 2) % S;
    int unsigned tg  = (pc >> 2) / S;
    h = 0; t = 32'h0; b = 0; j = 0; p = 0;
    for (int w = 0; w < W; w++)
      if (!h && m_valid[c][idx][w] && m_tag[c][idx][w] == tg) begin
        h = 1; t = m_tgt[c][idx][w]; b = m_br[c][idx][w]; j = !m_br[c][idx][w];
        p = !m_br[c][idx][w] || (m_ctr[c][idx][w] >= 2);
      end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s pc=%h: observed %h expected %h", tag, IF_pc, obs, exp);
    end
  endtask

  task automatic check_all();
    bit h, b, j, p;
    logic [31:0] t;
    for (int c = 0; c < 4; c++) begin
      model_lookup(c, IF_pc, h, t, b, j, p);
      check($sformatf("cfg%0d hit", c), {31'b0, hit_o[c]}, {31'b0, h});
      check($sformatf("cfg%0d target", c), tgt_o[c], t);
      check($sformatf("cfg%0d branch", c), {31'b0, br_o[c]}, {31'b0, b});
      check($sformatf("cfg%0d jump", c), {31'b0, jmp_o[c]}, {31'b0, j});
      check($sformatf("cfg%0d predict", c), {31'b0, pt_o[c]}, {31'b0, p});
    end
  endtask

  task automatic check_zero(input string tag);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s cfg%0d hit", tag, c), {31'b0, hit_o[c]}, 32'h0);
      check($sformatf("%s cfg%0d target", tag, c), tgt_o[c], 32'h0);
      check($sformatf("%s cfg%0d flags", tag, c), {29'b0, br_o[c], jmp_o[c], pt_o[c]}, 32'h0);
    end
  endtask

  // One clock: check the current lookup before the edge, then apply the model update.
  task automatic cycle();
    #3;
    check_all();
    @(posedge clk);
    if (flush) model_flush();
    else if (write) model_write();
    #1;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [31:0] tgt, input logic br, input logic tk);
    write = 1'b1; ID_pc = pc; pc_imm_in = tgt; ID_Branch = br; ID_taken = tk;
    cycle();
    write = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    IF_pc = pc; write = 1'b0; flush = 1'b0;
    cycle();
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned hi = $urandom_range(0, 3);
    int unsigned lo = $urandom_range(0, 63);
    int unsigned bb = $urandom_range(0, 3);
    return (hi << 12) | (lo << 2) | bb;
  endfunction

  initial begin
    rst_n = 1'b0; write = 1'b0; flush = 1'b0; ID_Branch = 1'b0; ID_taken = 1'b0;
    IF_pc = 32'h100; ID_pc = 32'h0; pc_imm_in = 32'h0;
    model_clear();
    #2;
    check_zero("reset");
    #5;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocation, and the same-cycle lookup still sees the old contents.
    IF_pc = 32'h100;
    write = 1'b1; ID_pc = 32'h100; pc_imm_in = 32'h200; ID_Branch = 1'b1; ID_taken = 1'b1;
    #1;
    check("same-cycle miss", {31'b0, hit_o[0]}, 32'h0);
    cycle();
    write = 1'b0;
    look(32'h100);
    check("alloc hit", {31'b0, hit_o[0]}, 32'h1);
    check("alloc target", tgt_o[0], 32'h200);
    check("alloc branch", {31'b0, br_o[0]}, 32'h1);
    check("alloc predict", {31'b0, pt_o[0]}, 32'h1);

    // In-place training toward not-taken, then a target rewrite.
    wr(32'h100, 32'h200, 1'b1, 1'b0);
    look(32'h100);
    check("nt1 predict", {31'b0, pt_o[0]}, 32'h0);
    wr(32'h100, 32'h200, 1'b1, 1'b0);
    wr(32'h100, 32'h200, 1'b1, 1'b0);
    look(32'h100);
    check("nt3 predict", {31'b0, pt_o[0]}, 32'h0);
    wr(32'h100, 32'h300, 1'b1, 1'b0);
    look(32'h100);
    check("retarget", tgt_o[0], 32'h300);
    wr(32'h140, 32'h444, 1'b1, 1'b1);
    look(32'h100);
    check("no dup 0x100", {31'b0, hit_o[0]}, 32'h1);
    look(32'h140);
    check("no dup 0x140", {31'b0, hit_o[0]}, 32'h1);

    // Flush, and flush together with a write.
    flush = 1'b1; cycle(); flush = 1'b0;
    look(32'h100);
    check("flush 0x100", {31'b0, hit_o[0]}, 32'h0);
    look(32'h140);
    check("flush 0x140", {31'b0, hit_o[0]}, 32'h0);
    flush = 1'b1; wr(32'h100, 32'h200, 1'b1, 1'b1); flush = 1'b0;
    look(32'h100);
    check("flush drops write", {31'b0, hit_o[0]}, 32'h0);

    // Round-robin replacement in set 0 of the 16x2 configuration.
    wr(32'h000, 32'h1000, 1'b1, 1'b1);
    wr(32'h040, 32'h1040, 1'b1, 1'b1);
    look(32'h000); check("fill 0x000", {31'b0, hit_o[0]}, 32'h1);
    look(32'h040); check("fill 0x040", {31'b0, hit_o[0]}, 32'h1);
    wr(32'h080, 32'h1080, 1'b1, 1'b1);
    look(32'h000); check("rr0 evict 0x000", {31'b0, hit_o[0]}, 32'h0);
    look(32'h040); check("rr0 keep 0x040", {31'b0, hit_o[0]}, 32'h1);
    wr(32'h0C0, 32'h10C0, 1'b1, 1'b1);
    look(32'h040); check("rr1 evict 0x040", {31'b0, hit_o[0]}, 32'h0);
    look(32'h080); check("rr1 keep 0x080", {31'b0, hit_o[0]}, 32'h1);
    wr(32'h100, 32'h1100, 1'b1, 1'b1);
    look(32'h080); check("wrap evict 0x080", {31'b0, hit_o[0]}, 32'h0);
    look(32'h0C0); check("wrap keep 0x0C0", {31'b0, hit_o[0]}, 32'h1);
    look(32'h100); check("wrap new 0x100", tgt_o[0], 32'h1100);

    // Jumps and a branch update of a jump entry.
    wr(32'h500, 32'h900, 1'b0, 1'b0);
    look(32'h500);
    check("jump flag", {31'b0, jmp_o[0]}, 32'h1);
    check("jump not branch", {31'b0, br_o[0]}, 32'h0);
    check("jump predict", {31'b0, pt_o[0]}, 32'h1);
    wr(32'h500, 32'h900, 1'b1, 1'b0);
    look(32'h500);
    check("jump->br nt predict", {31'b0, pt_o[0]}, 32'h1);
    wr(32'h500, 32'h900, 1'b1, 1'b0);
    look(32'h500);
    check("br 01 predict", {31'b0, pt_o[0]}, 32'h0);
    wr(32'h500, 32'h904, 1'b0, 1'b0);
    wr(32'h500, 32'h904, 1'b1, 1'b1);
    look(32'h500);
    check("sat 11 predict", {31'b0, pt_o[0]}, 32'h1);

    // Asynchronous reset in the middle of a cycle carrying a write.
    IF_pc = 32'h500;
    write = 1'b1; ID_pc = 32'h600; pc_imm_in = 32'h700; ID_Branch = 1'b1; ID_taken = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    model_clear();
    @(posedge clk);
    #2;
    write = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    look(32'h500);
    look(32'h600);
    check("reset lost write", {31'b0, hit_o[0]}, 32'h0);

    // Randomized traffic over a small address pool, against the model.
    for (int i = 0; i < 400; i++) begin
      IF_pc     = rand_pc();
      ID_pc     = rand_pc();
      pc_imm_in = $urandom;
      write     = 1'($urandom_range(0, 1));
      ID_Branch = 1'($urandom_range(0, 3) != 0);
      ID_taken  = 1'($urandom_range(0, 1));
      flush     = 1'($urandom_range(0, 39) == 0);
      cycle();
    end
    write = 1'b0; flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised N-way set-associative branch target buffer with per-entry 2-bit direction counters and per-set round-robin replacement. It sits between IF and ID, in the same place as the current fixed 2-way BTB. IF reads it combinationally to get a predicted target, instruction type and taken/not-taken prediction. ID writes resolved branch and jump information back one entry per cycle, updating an existing entry in place rather than allocating a duplicate.

## Interface
Parameters:
- NUM_SETS, 16: number of sets; power of 2, 2..256; SET_BITS = log2(NUM_SETS).
- NUM_WAYS, 2: ways per set; power of 2, 1..8.
- TAG_WIDTH, 30-SET_BITS: tag is pc[31:2+SET_BITS]; index is pc[2+SET_BITS-1:2].

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_pc  in  32  fetch PC to look up.
- pc_imm_out  out  32  predicted target of the hitting way; 0 on miss.
- hit  out  1  IF_pc matches a valid entry.
- IF_Branch  out  1  hitting entry is a conditional branch.
- IF_Jump  out  1  hitting entry is a jump.
- predict_taken  out  1  hit && (IF_Jump || ctr[1]).
- write  in  1  ID update request, one per cycle.
- ID_pc  in  32  PC of the resolved instruction.
- pc_imm_in  in  32  resolved target.
- ID_Branch  in  1  1 = branch, 0 = jump.
- ID_taken  in  1  resolved direction; ignored for jumps.
- flush  in  1  synchronous invalidate of all entries.

## Operation
- Entry fields: valid, tag[TAG_WIDTH], target[32], is_branch, ctr[2].
- Per-set state: rr_ptr[log2(NUM_WAYS)].
- With NUM_WAYS = 1, rr_ptr is absent and way 0 is always the victim.

Lookup (combinational, from IF_pc):
- Compare the tag against every valid way of the indexed set.
- If more than one way matches, which cannot occur by construction, the lowest way index wins.
- On a miss, all outputs are 0.

Update, when write = 1 and flush = 0:
- **Hit in way w:** overwrite target and is_branch.
  - Branch: ctr saturates up if ID_taken, down otherwise (00..11).
  - Jump: ctr is forced to 11.
  - rr_ptr is unchanged.
- **Miss, invalid way present:** allocate the lowest-index invalid way; rr_ptr is unchanged.
- **Miss, set full:** allocate way rr_ptr; rr_ptr <= rr_ptr+1, wrapping modulo NUM_WAYS.
- **Allocated entry:** valid=1, tag and target from ID_pc and pc_imm_in.
  - Branch: ctr = ID_taken ? 10 : 01.
  - Jump: ctr = 11.
- Only the indexed set changes; all other sets hold.

Flush and reset:
- flush = 1: clear every valid bit and every rr_ptr on the next edge. Flush takes priority over write, and the write is dropped.
- rst_n = 0: immediately clear all valid bits, all rr_ptr, all ctr (to 00) and all targets/tags (to 0), independent of clk. Deassertion is synchronous to the design and needs no special handling inside the block.

## Timing
- Lookup latency is zero: outputs follow IF_pc within the same cycle.
- Updates become visible on the cycle after the write edge.
- Simultaneous lookup and update of the same entry: the lookup returns the pre-update contents (old target, old ctr, or miss if it is being allocated). The new contents appear next cycle; no bypass.
- Output values during and after reset, until the first write: hit=0, pc_imm_out=0, IF_Branch=0, IF_Jump=0, predict_taken=0.
- Reset asserted mid-update: the update is lost and the array is cleared.
- Counter arithmetic is 2-bit saturating; an update never wraps 11->00 or 00->11.
- rr_ptr arithmetic wraps modulo NUM_WAYS by natural width truncation.

## Test plan
- **Reset/flush:** assert rst_n=0 asynchronously mid-cycle -> hit=0, pc_imm_out=0, all other outputs 0 immediately; write entries, pulse flush -> every prior PC misses next cycle; flush together with write -> the entry is not installed.
- **Allocate and hit:** write ID_pc=0x100, pc_imm_in=0x200, ID_Branch=1, ID_taken=1 -> next cycle IF_pc=0x100 gives hit=1, pc_imm_out=0x200, IF_Branch=1, predict_taken=1 (ctr=10); same-cycle lookup of 0x100 still misses.
- **In-place update:** three not-taken writes to the same 0x100 -> ctr 10->01->00->00, predict_taken=0 from the first update; target rewritten to 0x300 gives pc_imm_out=0x300; the entry uses no extra way.
- **Replacement (NUM_SETS=16, NUM_WAYS=2):**
  - Fill set 0 with 0x000 and 0x040 -> both hit.
  - Write 0x080 -> replaces way 0 (0x000 misses, 0x040 hits).
  - Write 0x0C0 -> replaces way 1 (0x040 misses).
  - Write 0x100 -> replaces way 0 again, showing rr_ptr wrap.
- **Jumps:** write a jump with ID_taken=0 -> IF_Jump=1, IF_Branch=0, predict_taken=1; a later branch update of the same PC sets ctr from 11 to 11 or 10 according to ID_taken.
- **Parameter sweep:** repeat the scenarios with NUM_WAYS=1,4,8 and NUM_SETS=2,64 -> no cross-set corruption, and the tag/index split matches the parameters.
